// File: rtl/fdiv_issue_arbiter_pkg.sv
// fdiv_issue_arbiter_pkg: shared types for the FP divider issue arbiter.
// Contents: o_err_t divider error code, fdiv_arb_state_t FSM states, FDIV_ARB_NREQ_MAX.
package fdiv_issue_arbiter_pkg;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        INVALID   = 3'd1,
        DIVBYZERO = 3'd2,
        OVERFLOW  = 3'd3,
        UNDERFLOW = 3'd4,
        INEXACT   = 3'd5
    } o_err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fdiv_arb_state_t;

    localparam int FDIV_ARB_NREQ_MAX = 8;

endpackage

// File: rtl/fdiv_issue_arbiter_rr_arbiter.sv
// fdiv_issue_arbiter_rr_arbiter: combinational round-robin pick of the first request at or after ptr_i.
// Ports:
//   req_i    in  NREQ  request bits
//   ptr_i    in  IDW   search start position
//   gnt_o    out NREQ  one-hot grant (zero when no request)
//   gnt_id_o out IDW   index of the granted bit
//   any_o    out 1     some request is pending
module fdiv_issue_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            any_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_i) + i) % NREQ);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/fdiv_issue_arbiter.sv
// fdiv_issue_arbiter: shares one iterative FP divider among NREQ requesters, one divide in flight.
// Optional feature macro: FDIV_ISSUE_ARB_FLUSH_EN (adds flush_i / flush_id_i to kill an in-flight op).
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        per-requester handshake, ready is one-hot, only in IDLE
//   req_a_i/req_b_i/req_rm_i       packed operands and rounding modes, lane i at [32*i +: 32] / [2*i +: 2]
//   rsp_valid_o/rsp_ready_i        result handshake
//   rsp_id_o/rsp_s_o/rsp_err_o     requester id, quotient, error code
//   div_a_o/div_b_o/div_rm_o       operands to divider, held from ISSUE to completion
//   div_fdiv_o/div_ena_o           one-cycle start pulse, divider enable
//   div_busy_i/div_s_i/div_err_i   divider status and result
//   arb_busy_o                     arbiter not idle
module fdiv_issue_arbiter
    import fdiv_issue_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*32-1:0] req_a_i,
    input  logic [NREQ*32-1:0] req_b_i,
    input  logic [NREQ*2-1:0] req_rm_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [31:0]       rsp_s_o,
    output o_err_t            rsp_err_o,
    output logic [31:0]       div_a_o,
    output logic [31:0]       div_b_o,
    output logic [1:0]        div_rm_o,
    output logic              div_fdiv_o,
    output logic              div_ena_o,
    input  logic              div_busy_i,
    input  logic [31:0]       div_s_i,
    input  o_err_t            div_err_i,
`ifdef FDIV_ISSUE_ARB_FLUSH_EN
    input  logic              flush_i,
    input  logic [IDW-1:0]    flush_id_i,
`endif
    output logic              arb_busy_o
);

    fdiv_arb_state_t state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d, gnt_id;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic [31:0]     a_q, a_d, b_q, b_d, s_q, s_d;
    logic [1:0]      rm_q, rm_d, cnt_q, cnt_d;
    o_err_t          err_q, err_d;
    logic            busy_q, seen_q, seen_d, kill_q, kill_d, done, flush_hit;

    fdiv_issue_arbiter_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i    (req_valid_i),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (gnt_any)
    );

`ifdef FDIV_ISSUE_ARB_FLUSH_EN
    assign flush_hit = flush_i && (flush_id_i == id_q);
`else
    assign flush_hit = 1'b0;
`endif

    // Completion is the falling edge of div_busy; a divider that never raises busy
    // within two cycles of ISSUE is treated as done on the second WAIT cycle.
    assign done = (busy_q && !div_busy_i) || (cnt_q == 2'd2 && !seen_q && !div_busy_i);

    assign req_ready_o = (state_q == IDLE) ? gnt : '0;
    assign rsp_valid_o = state_q == RESP;
    assign arb_busy_o  = state_q != IDLE;
    assign div_fdiv_o  = state_q == ISSUE;
    assign div_ena_o   = (state_q == ISSUE) || (state_q == WAIT);
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign div_rm_o    = rm_q;
    assign rsp_id_o    = id_q;
    assign rsp_s_o     = s_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        rm_d    = rm_q;
        s_d     = s_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        kill_d  = kill_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = ISSUE;
                    id_d    = gnt_id;
                    ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                    kill_d  = 1'b0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            a_d  = req_a_i[32*i +: 32];
                            b_d  = req_b_i[32*i +: 32];
                            rm_d = req_rm_i[2*i +: 2];
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 2'd1;
                seen_d  = 1'b0;
                kill_d  = kill_q | flush_hit;
            end
            WAIT: begin
                seen_d = seen_q | div_busy_i;
                cnt_d  = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
                kill_d = kill_q | flush_hit;
                if (done) begin
                    state_d = (kill_q | flush_hit) ? IDLE : RESP;
                    s_d     = (kill_q | flush_hit) ? s_q : div_s_i;
                    err_d   = (kill_q | flush_hit) ? err_q : div_err_i;
                end
            end
            RESP: begin
                if (rsp_ready_i || flush_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            s_q     <= '0;
            err_q   <= NONE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            kill_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rm_q    <= rm_d;
            s_q     <= s_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            kill_q  <= kill_d;
            busy_q  <= div_busy_i;
        end
    end

endmodule

// File: tb/tb_fdiv_issue_arbiter.sv
// tb_fdiv_issue_arbiter: directed self-checking bench for fdiv_issue_arbiter with a behavioural divider.
module tb_fdiv_issue_arbiter;
    import fdiv_issue_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [7:0]   req_rm = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_s;
    o_err_t       rsp_err;
    logic [31:0]  div_a, div_b;
    logic [31:0]  div_s;
    logic [1:0]   div_rm;
    logic         div_fdiv, div_ena, div_busy, arb_busy;
    o_err_t       div_err;
    bit           no_busy = 1'b0;
    int           lat_cnt;
    int           n_chk = 0;
    int           n_fail = 0;
    bit           ok;
`ifdef FDIV_ISSUE_ARB_FLUSH_EN
    logic         flush = 1'b0;
    logic [1:0]   flush_id = '0;
    bit           seen;
`endif

    always #5 clk = ~clk;

    fdiv_issue_arbiter #(.NREQ(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_rm_i    (req_rm),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_s_o     (rsp_s),
        .rsp_err_o   (rsp_err),
        .div_a_o     (div_a),
        .div_b_o     (div_b),
        .div_rm_o    (div_rm),
        .div_fdiv_o  (div_fdiv),
        .div_ena_o   (div_ena),
        .div_busy_i  (div_busy),
        .div_s_i     (div_s),
        .div_err_i   (div_err),
`ifdef FDIV_ISSUE_ARB_FLUSH_EN
        .flush_i     (flush),
        .flush_id_i  (flush_id),
`endif
        .arb_busy_o  (arb_busy)
    );

    function automatic logic [31:0] res_s(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) ? 32'h7F800000 :
               (a == 32'h40C00000 && b == 32'h40000000) ? 32'h40400000 : {a[31:16], b[15:0]};
    endfunction

    // Divider stand-in: busy for three cycles after the start pulse, or no busy at all when no_busy is set.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_busy <= 1'b0;
            lat_cnt  <= 0;
            div_s    <= '0;
            div_err  <= NONE;
        end else if (div_fdiv) begin
            if (no_busy) begin
                div_s   <= res_s(div_a, div_b);
                div_err <= (div_b == 32'h0) ? DIVBYZERO : NONE;
            end else begin
                div_busy <= 1'b1;
                lat_cnt  <= 3;
            end
        end else if (div_busy) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                div_busy <= 1'b0;
                div_s    <= res_s(div_a, div_b);
                div_err  <= (div_b == 32'h0) ? DIVBYZERO : NONE;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp();
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_s", 64'(rsp_s), 64'h0);
        chk("rst_rsp_err", 64'(rsp_err), 64'(NONE));
        chk("rst_div_fdiv", 64'(div_fdiv), 64'h0);
        chk("rst_div_ena", 64'(div_ena), 64'h0);
        chk("rst_div_ops", {div_a, div_b}, 64'h0);
        chk("rst_arb_busy", 64'(arb_busy), 64'h0);
        rstn = 1'b1;
        @(negedge clk);
        // 6.0 / 2.0 from requester 0
        req_a[31:0] = 32'h40C00000;
        req_b[31:0] = 32'h40000000;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1 chk("r0_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("r0_fdiv", 64'(div_fdiv), 64'h1);
        chk("r0_ena", 64'(div_ena), 64'h1);
        chk("r0_ops", {div_a, div_b}, 64'h40C00000_40000000);
        chk("r0_busy", 64'(arb_busy), 64'h1);
        @(negedge clk);
        chk("r0_fdiv_once", 64'(div_fdiv), 64'h0);
        chk("r0_ena_wait", 64'(div_ena), 64'h1);
        wait_rsp();
        chk("r0_id", 64'(rsp_id), 64'h0);
        chk("r0_s", 64'(rsp_s), 64'h40400000);
        chk("r0_err", 64'(rsp_err), 64'(NONE));
        @(negedge clk);
        chk("r0_rsp_drop", 64'(rsp_valid), 64'h0);
        // 1.0 / 0.0 from requester 1, rm=2
        req_a[63:32] = 32'h3F800000;
        req_b[63:32] = 32'h00000000;
        req_rm[3:2] = 2'b10;
        req_valid = 4'b0010;
        #1 chk("r1_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("r1_rm", 64'(div_rm), 64'h2);
        chk("r1_a", 64'(div_a), 64'h3F800000);
        wait_rsp();
        chk("r1_id", 64'(rsp_id), 64'h1);
        chk("r1_s", 64'(rsp_s), 64'h7F800000);
        chk("r1_err", 64'(rsp_err), 64'(DIVBYZERO));
        @(negedge clk);
        // Reset to bring the pointer back to 0, then all four requesters contend
        rstn = 1'b0;
        @(negedge clk);
        chk("rst2_busy", 64'(arb_busy), 64'h0);
        rstn = 1'b1;
        req_rm = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'hA0000000 | (i << 16);
            req_b[32*i +: 32] = 32'h0000B000 | i;
        end
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            int w = 0;
            while (req_ready == 4'b0 && w < 30) begin
                @(negedge clk);
                w++;
            end
            chk("rr_seen", 64'(req_ready != 4'b0), 64'h1);
            chk("rr_onehot", 64'($onehot0(req_ready)), 64'h1);
            chk("rr_order", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            wait_rsp();
            chk("rr_id", 64'(rsp_id), 64'(k % 4));
            chk("rr_s", 64'(rsp_s), 64'(32'hA000B000 | ((k % 4) << 16) | (k % 4)));
        end
        req_valid = 4'b0000;
        @(negedge clk);
        // Back-pressure in RESP: requester 2 (pointer is 1, only 2 requests)
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1 chk("bp_ready", 64'(req_ready), 64'h4);
        wait_rsp();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_s", 64'(rsp_s), 64'hA002B002);
            chk("bp_id", 64'(rsp_id), 64'h2);
            chk("bp_no_ready", 64'(req_ready), 64'h0);
            chk("bp_no_fdiv", 64'(div_fdiv), 64'h0);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("bp_release", 64'(rsp_valid), 64'h0);
        chk("bp_idle", 64'(arb_busy), 64'h0);
        // Reset during WAIT (requester 3 in flight)
        req_valid = 4'b1000;
        #1 chk("rw_ready", 64'(req_ready), 64'h8);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rw_in_wait", 64'(div_ena), 64'h1);
        rstn = 1'b0;
        #1;
        chk("rw_busy", 64'(arb_busy), 64'h0);
        chk("rw_ena", 64'(div_ena), 64'h0);
        chk("rw_ops", {div_a, div_b}, 64'h0);
        chk("rw_rsp", {30'h0, rsp_id, rsp_s}, 64'h0);
        chk("rw_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        req_valid = 4'b1111;
        #1 chk("rw_fresh_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp();
        chk("rw_fresh_id", 64'(rsp_id), 64'h0);
        chk("rw_fresh_s", 64'(rsp_s), 64'hA000B000);
        @(negedge clk);
        // Divider that never raises busy: completion on the second WAIT cycle
        no_busy = 1'b1;
        req_valid = 4'b0010;
        #1 chk("nb_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("nb_not_yet", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        chk("nb_valid", 64'(rsp_valid), 64'h1);
        chk("nb_s", 64'(rsp_s), 64'hA001B001);
        chk("nb_id", 64'(rsp_id), 64'h1);
        no_busy = 1'b0;
        @(negedge clk);
`ifdef FDIV_ISSUE_ARB_FLUSH_EN
        // Flush the in-flight requester 2 during WAIT
        req_valid = 4'b0100;
        #1 chk("fl_ready", 64'(req_ready), 64'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        flush = 1'b1;
        flush_id = 2'd2;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("fl_no_rsp", 64'(seen), 64'h0);
        chk("fl_idle", 64'(arb_busy), 64'h0);
        req_valid = 4'b0001;
        #1 chk("fl_next_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        flush = 1'b1;
        flush_id = 2'd1;
        @(negedge clk);
        flush = 1'b0;
        wait_rsp();
        chk("fl_nomatch_id", 64'(rsp_id), 64'h0);
        @(negedge clk);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
